// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter - round-robin shared radix-2 Booth signed multiplier for NREQ requesters.
// Define BOOTH_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module booth_mul_arbiter #(
  parameter int SIZE = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] a_in,
  input  logic [NREQ*SIZE-1:0] b_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic [2*SIZE-1:0]    out
);

  localparam int PW = 2*SIZE + 2;
  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state_q;
  logic [SIZE:0]      a_q;
  logic [PW-1:0]      p_q;
  logic [IDW-1:0]     id_q;
  logic [CW-1:0]      cnt_q;
  logic [NREQ-1:0]    gnt_q;
  logic               busy_q;
  logic               done_q;
  logic [IDW-1:0]     done_id_q;
  logic [2*SIZE-1:0]  out_q;
`ifndef BOOTH_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]     last_q;
`endif

  logic [NREQ-1:0]    rot_d;
  logic [IDW:0]       start_d;
  logic [IDW:0]       off_d;
  logic [IDW:0]       sum_idx_d;
  logic               win_found_d;
  logic [IDW-1:0]     win_id_d;
  logic [SIZE-1:0]    a_sel_d;
  logic [SIZE-1:0]    b_sel_d;
  logic [SIZE:0]      acc_d;
  logic [PW-1:0]      p_step_d;

  // Rotate req so the search always starts at bit 0, then map the offset back.
  always_comb begin
`ifdef BOOTH_ARB_FIXED_PRIO_EN
    start_d = '0;
    rot_d   = req;
`else
    if (last_q == IDW'(NREQ-1)) start_d = '0;
    else                        start_d = {1'b0, last_q} + (IDW+1)'(1);
    rot_d = NREQ'({req, req} >> start_d);
`endif
    win_found_d = 1'b0;
    off_d       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found_d && rot_d[i]) begin
        win_found_d = 1'b1;
        off_d       = (IDW+1)'(i);
      end
    end
    sum_idx_d = start_d + off_d;
    if (sum_idx_d >= (IDW+1)'(NREQ)) sum_idx_d = sum_idx_d - (IDW+1)'(NREQ);
    win_id_d = IDW'(sum_idx_d);
    a_sel_d  = '0;
    b_sel_d  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_id_d == IDW'(k)) begin
        a_sel_d = a_in[k*SIZE +: SIZE];
        b_sel_d = b_in[k*SIZE +: SIZE];
      end
    end
  end

  // One Booth step: add/sub into the SIZE+1-bit upper half, then arithmetic shift.
  always_comb begin
    acc_d = p_q[PW-1:SIZE+1];
    case (p_q[1:0])
      2'b01:   acc_d = p_q[PW-1:SIZE+1] + a_q;
      2'b10:   acc_d = p_q[PW-1:SIZE+1] - a_q;
      default: acc_d = p_q[PW-1:SIZE+1];
    endcase
    p_step_d = {acc_d[SIZE], acc_d, p_q[SIZE:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      p_q       <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      out_q     <= '0;
`ifndef BOOTH_ARB_FIXED_PRIO_EN
      last_q    <= IDW'(NREQ-1);
`endif
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found_d) begin
            gnt_q   <= NREQ'(1) << win_id_d;
            a_q     <= {a_sel_d[SIZE-1], a_sel_d};
            p_q     <= {{(SIZE+1){1'b0}}, b_sel_d, 1'b0};
            id_q    <= win_id_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
`ifndef BOOTH_ARB_FIXED_PRIO_EN
            last_q  <= win_id_d;
`endif
          end
        end
        CALC: begin
          p_q   <= p_step_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(SIZE-1)) state_q <= FIN;
        end
        FIN: begin
          out_q     <= p_q[2*SIZE:1];
          done_id_q <= id_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign out     = out_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - scoreboard bench for booth_mul_arbiter (SIZE=8, NREQ=4).
module tb_booth_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic [15:0] out;

  int vectors;
  int miscompares;
  int model_last;
  logic [15:0] exp_p_q[$];
  int          exp_id_q[$];

  booth_mul_arbiter #(.SIZE(8), .NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .out(out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] p;
    p = 16'($signed(a)) * 16'($signed(b));
    return p;
  endfunction

  function automatic int model_win(input logic [3:0] m);
    int j;
`ifdef BOOTH_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (m[i]) return i;
`else
    for (int i = 0; i < 4; i++) begin
      j = (model_last + 1 + i) % 4;
      if (m[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
    a_in = (a_in & ~(32'hFF << (8*k))) | (32'(a) << (8*k));
    b_in = (b_in & ~(32'hFF << (8*k))) | (32'(b) << (8*k));
  endtask

  task automatic run_sched(input logic [3:0] init_mask, input logic [3:0] add_mask,
                           input bit drop, input int ngrants);
    int grants, last_done, w, eid;
    bit fin;
    logic [15:0] ep;
    grants = 0; last_done = -1; fin = 1'b0;
    req = init_mask;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk);
      if (gnt !== 4'b0) begin
        w = model_win(req);
        vectors++;
        if (w < 0 || gnt !== 4'(1 << w)) begin
          $display("FAIL gnt: got %b, want id %0d", gnt, w);
          miscompares++;
        end
        vectors++;
        if (done === 1'b1) begin
          $display("FAIL gnt_done_overlap: gnt=%b done=%b, want done=0", gnt, done);
          miscompares++;
        end
        if (w >= 0) begin
          exp_p_q.push_back(prod(8'(a_in >> (8*w)), 8'(b_in >> (8*w))));
          exp_id_q.push_back(w);
          model_last = w;
          if (drop) req = req & ~(4'b1 << w);
          set_ops(w, 8'($urandom), 8'($urandom));
        end
        grants++;
        if (grants == 1) req = req | add_mask;
        if (grants >= ngrants) req = 4'b0;
      end
      if (done === 1'b1) begin
        vectors++;
        if (exp_id_q.size() == 0) begin
          $display("FAIL spurious_done: got done=1 id=%0d, want no done", done_id);
          miscompares++;
        end else begin
          ep  = exp_p_q.pop_front();
          eid = exp_id_q.pop_front();
          if (out !== ep || done_id !== 2'(eid)) begin
            $display("FAIL product: got out=%h id=%0d, want out=%h id=%0d", out, done_id, ep, eid);
            miscompares++;
          end
          if (last_done >= 0) begin
            vectors++;
            if (cyc - last_done != 10) begin
              $display("FAIL done_spacing: got %0d cycles, want 10", cyc - last_done);
              miscompares++;
            end
          end
          last_done = cyc;
        end
      end
      if (grants >= ngrants && exp_id_q.size() == 0) fin = 1'b1;
    end
    vectors++;
    if (!fin) begin
      $display("FAIL sched_timeout: got %0d grants, %0d pending, want %0d grants, 0 pending",
               grants, exp_id_q.size(), ngrants);
      miscompares++;
      exp_p_q.delete();
      exp_id_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b0; a_in = '0; b_in = '0;
    model_last = 3;
    repeat (2) @(negedge clk);
    vectors++; if (gnt !== 4'b0)   begin $display("FAIL reset_gnt: got %b want 0", gnt); miscompares++; end
    vectors++; if (busy !== 1'b0)  begin $display("FAIL reset_busy: got %b want 0", busy); miscompares++; end
    vectors++; if (done !== 1'b0)  begin $display("FAIL reset_done: got %b want 0", done); miscompares++; end
    vectors++; if (done_id !== 2'b0) begin $display("FAIL reset_id: got %0d want 0", done_id); miscompares++; end
    vectors++; if (out !== 16'h0)  begin $display("FAIL reset_out: got %h want 0", out); miscompares++; end
    rst = 1'b1;
  endtask

  task automatic test_single();
    int busy_cnt, done_at;
    logic [15:0] got_out;
    logic [1:0]  got_id;
    set_ops(0, 8'd3, 8'hFB);
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0) break;
    end
    vectors++;
    if (gnt !== 4'b0001) begin $display("FAIL single_gnt: got %b want 0001", gnt); miscompares++; end
    req = 4'b0; model_last = 0;
    busy_cnt = 0; done_at = -1; got_out = '0; got_id = '0;
    for (int k = 0; k < 20; k++) begin
      if (k == 1) begin
        vectors++;
        if (gnt !== 4'b0) begin $display("FAIL gnt_pulse: got %b want 0", gnt); miscompares++; end
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 && done_at < 0) begin done_at = k; got_out = out; got_id = done_id; end
      @(negedge clk);
    end
    vectors++; if (done_at != 9) begin $display("FAIL single_latency: got %0d want 9", done_at); miscompares++; end
    vectors++; if (busy_cnt != 9) begin $display("FAIL single_busy: got %0d want 9", busy_cnt); miscompares++; end
    vectors++;
    if (got_out !== 16'hFFF1 || got_id !== 2'd0) begin
      $display("FAIL single_out: got %h id %0d want fff1 id 0", got_out, got_id);
      miscompares++;
    end
  endtask

  task automatic test_corners();
    logic [7:0]  ta[4];
    logic [7:0]  tb[4];
    logic [15:0] tp[4];
    ta = '{8'h80, 8'h80, 8'h7F, 8'h00};
    tb = '{8'h80, 8'h7F, 8'h7F, 8'h80};
    tp = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000};
    for (int k = 0; k < 4; k++) begin
      set_ops(k, ta[k], tb[k]);
      run_sched(4'(1 << k), 4'b0, 1'b1, 1);
      vectors++;
      if (out !== tp[k] || done_id !== 2'(k)) begin
        $display("FAIL corner%0d: got %h id %0d want %h id %0d", k, out, done_id, tp[k], k);
        miscompares++;
      end
    end
  endtask

  task automatic test_round_robin();
    a_in = $urandom; b_in = $urandom;
    run_sched(4'b1111, 4'b0, 1'b0, 8);
  endtask

  task automatic test_midflight();
    a_in = $urandom; b_in = $urandom;
    run_sched(4'b0001, 4'b0110, 1'b1, 3);
  endtask

  task automatic test_prio_mix();
    a_in = $urandom; b_in = $urandom;
    run_sched(4'b1001, 4'b0, 1'b0, 6);
  endtask

  task automatic test_reset_midop();
    int seen;
    set_ops(1, 8'h55, 8'h93);
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0) break;
    end
    vectors++;
    if (gnt !== 4'b0010) begin $display("FAIL midop_gnt: got %b want 0010", gnt); miscompares++; end
    req = 4'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({gnt, busy, done, done_id, out} !== 24'h0) begin
      $display("FAIL midop_reset: got gnt=%b busy=%b done=%b id=%0d out=%h want all 0",
               gnt, busy, done, done_id, out);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b1; model_last = 3;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin $display("FAIL midop_ghost: got %0d active cycles want 0", seen); miscompares++; end
    set_ops(2, 8'hE7, 8'h21);
    run_sched(4'b0100, 4'b0, 1'b1, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0;
    test_reset();
    test_single();
    test_corners();
    test_round_robin();
    test_midflight();
    test_prio_mix();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
